prbs31_rx_checker: RTL
======================

// Module: prbs31_rx_checker
// PURPOSE
//  Checks a PRBS31 stream (x^31+x^28+1) received on SFP0 against the LFSR pattern transmitted by gth_driver.
//  Sits in the GTH rx user-clock domain; all inputs and outputs are synchronous to clk.
//  Acquires lock by self-synchronising from the received data, then free-runs its own LFSR.
//  Reports lock state, word and bit error counts and lock-loss events to the register map.
// PARAMETERS
//  W         32  data word width; must be >= 32.
//  CW        32  width of the statistics counters.
//  LOCK_GOOD 16  consecutive good words needed to go from VERIFY to LOCKED.
//  LOSE_BAD   4  bad words inside one window that force loss of lock.
//  LOSE_WIN  64  window length, in valid words, used for the LOSE_BAD test.
// PORTS
//  clk          in   1   rx user clock (the sfp_rxclk domain)
//  rst          in   1   synchronous, active-high reset
//  clr          in   1   synchronous clear of all counters; lock state is kept
//  rx_data      in   W   received word; bit 0 is the earliest bit in sequence order
//  rx_vld       in   1   rx_data is valid this cycle
//  locked       out  1   state == LOCKED
//  lock_lost    out  1   one-cycle pulse on the LOCKED->HUNT transition
//  err          out  1   registered mismatch flag for the word compared last cycle
//  state        out  2   0=HUNT, 1=VERIFY, 2=LOCKED
//  word_cnt     out  CW  valid words compared while LOCKED (saturating)
//  err_word_cnt out  CW  mismatched words while LOCKED (saturating)
//  err_bit_cnt  out  CW  mismatched bits while LOCKED (saturating); present only with the macro
// BEHAVIOUR
//  Reset: every output is 0 and state is HUNT. The LFSR state and the input register are also cleared.
//  Pipeline:
//   - Edge k: rx_data/rx_vld are registered into d_q/v_q.
//   - Cycle k+1: d_q is compared with the expected word.
//   - Edge k+2: state, err and all counters update.
//   - Total latency from input to outputs is 2 clocks. Cycles with v_q=0 change nothing.
//  Expected word:
//   - In HUNT and VERIFY: prbs31_next(previous valid word), i.e. self-synchronising.
//   - In LOCKED: the internal LFSR advances W bits per valid word and is never reloaded from data,
//     so a single bit error does not propagate.
//   - Recurrence: s[n] = s[n-31] ^ s[n-28].
//  A valid word that is all zeros is always treated as bad in HUNT and VERIFY (LFSR lock-up guard).
//  State machine:
//   - HUNT: each nonzero valid word is captured as the seed, then go to VERIFY with good_cnt=0.
//   - VERIFY: a good word does good_cnt++. When good_cnt reaches LOCK_GOOD, load the LFSR with the
//     last 31 bits of the word and go to LOCKED. A bad word returns to HUNT.
//   - LOCKED: win_cnt counts valid words and bad_cnt counts mismatches. If bad_cnt reaches LOSE_BAD
//     go to HUNT and pulse lock_lost. When win_cnt reaches LOSE_WIN with fewer bad words, both
//     counts restart at 0. The bad word that ends a window counts toward the expiring window.
//  Counters:
//   - They count only in LOCKED, including the word that causes loss of lock.
//   - They saturate at 2^CW-1 and never wrap.
//   - If clr and an increment occur in the same cycle, clr wins and the counter is 0.
//   - rst or clr mid-operation takes effect at the next edge; words already in the pipeline are dropped.
//  err_bit_cnt adds popcount(d_q ^ expected), a value from 0 to W, each compared word.
// CONFIGURATION
//  PRBS31_CHK_BITERR_EN defined: the err_bit_cnt port exists, along with a pipelined adder-tree
//   popcount. The popcount adds 1 cycle of latency, but only to err_bit_cnt.
//  PRBS31_CHK_BITERR_EN undefined: no err_bit_cnt port and no popcount logic. Word-level error
//   counting is unchanged.
// STRUCTURE
//  prbs31_pkg holds:
//   - the state enum (HUNT/VERIFY/LOCKED);
//   - the PRBS31 tap constants;
//   - the function prbs31_next(word) -> next W-bit word, parallelised;
//   - a function returning the all-zero test.
//  Sub-module prbs31_par_gen: a registered W-bit parallel LFSR with load, seed and adv inputs.
//  It is reused by the free-running path and is a candidate for a future gth_driver refactor.
//  Top level: input register, comparator, FSM, window counters, saturating counters.
// TESTING
//  1. rst, then 20 consecutive PRBS31 words with rx_vld=1 -> locked rises 2 clocks after word 17
//     (1 seed + 16 good); word_cnt=3 at the end; err_word_cnt=0.
//  2. While LOCKED, flip bit 5 of one word -> err=1 for exactly 1 cycle, err_word_cnt=1,
//     err_bit_cnt=1 (macro on); the next words produce no errors; locked stays 1.
//  3. While LOCKED, corrupt 4 words within 64 -> lock_lost pulses once, state=0.
//     Clean data then relocks after 17 words.
//  4. Corrupt 3 words in window 1 and 3 in window 2 -> no loss of lock; err_word_cnt=6.
//  5. An all-zero stream, or a random non-PRBS stream, for 1000 words -> locked never asserts;
//     state never reaches 2.
//  6. rx_vld=1 every other cycle while LOCKED -> word_cnt advances only on valid words.
//     With CW=4 it saturates at 15. clr asserted together with an error -> all counters 0.

Source files
------------

// File: rtl/prbs31_pkg.sv
// prbs31_pkg: shared types, constants and helper functions for the PRBS31
// (x^31 + x^28 + 1) receive checker and its parallel LFSR generator.
//
// Contents:
//   chk_state_e     checker state encoding (HUNT=0, VERIFY=1, LOCKED=2)
//   PRBS31_LEN/TAP  recurrence taps: s[n] = s[n-31] ^ s[n-28]
//   PRBS31_MAX_W    widest data word the helpers support
//   prbs31_next     next PRBS31_MAX_W sequence bits following a 31-bit history
//   prbs31_is_zero  all-zero word test (LFSR lock-up guard)
package prbs31_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

    localparam int PRBS31_LEN   = 31;
    localparam int PRBS31_TAP   = 28;
    localparam int PRBS31_MAX_W = 256;

    // Only the last 31 bits of a word determine everything that follows it,
    // so the parallel step takes that tail and unrolls the recurrence.
    // Bit 0 of tail and of the result is the earliest in sequence order;
    // callers keep the low W bits of the result.
    function automatic logic [PRBS31_MAX_W-1:0] prbs31_next(
        input logic [PRBS31_LEN-1:0] tail
    );
        logic [PRBS31_MAX_W+PRBS31_LEN-1:0] ext;
        ext = '0;
        ext[PRBS31_LEN-1:0] = tail;
        for (int i = PRBS31_LEN; i < PRBS31_MAX_W + PRBS31_LEN; i++) begin
            ext[i] = ext[i-PRBS31_LEN] ^ ext[i-PRBS31_TAP];
        end
        return ext[PRBS31_MAX_W+PRBS31_LEN-1:PRBS31_LEN];
    endfunction

    function automatic logic prbs31_is_zero(input logic [PRBS31_MAX_W-1:0] word);
        return (word == '0);
    endfunction

endpackage

// File: rtl/prbs31_par_gen.sv
// prbs31_par_gen: registered W-bit parallel PRBS31 generator.
// Holds the last 31 sequence bits; word is the W bits that follow them.
//
// Ports:
//   clk   in   1   clock
//   rst   in   1   synchronous active-high reset (clears the LFSR)
//   load  in   1   replace the LFSR with seed (wins over adv)
//   adv   in   1   step the LFSR forward by W bits
//   seed  in   31  history bits to load, bit 0 earliest
//   word  out  W   next W sequence bits, bit 0 earliest
module prbs31_par_gen
    import prbs31_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  adv,
    input  logic [PRBS31_LEN-1:0] seed,
    output logic [W-1:0]          word
);

    logic [PRBS31_LEN-1:0] lfsr_q;
    logic [PRBS31_LEN-1:0] lfsr_d;

    // After advancing, the new history is simply the top 31 bits of the
    // word just produced.
    always_comb begin
        word   = W'(prbs31_next(lfsr_q));
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (adv) begin
            lfsr_d = word[W-1:W-PRBS31_LEN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/prbs31_rx_checker.sv
// prbs31_rx_checker: checks a received PRBS31 stream, acquires lock by
// self-synchronising, then free-runs its own LFSR and counts errors.
// Optional feature macro: PRBS31_CHK_BITERR_EN adds err_bit_cnt and a
// pipelined popcount (one extra cycle of latency on err_bit_cnt only).
//
// Ports:
//   clk           in   1   rx user clock
//   rst           in   1   synchronous active-high reset
//   clr           in   1   clear all statistics counters, lock state kept
//   rx_data       in   W   received word, bit 0 earliest
//   rx_vld        in   1   rx_data valid
//   locked        out  1   state is LOCKED
//   lock_lost     out  1   one-cycle pulse on LOCKED -> HUNT
//   err           out  1   mismatch flag of the last compared word
//   state         out  2   0=HUNT, 1=VERIFY, 2=LOCKED
//   word_cnt      out  CW  words compared while LOCKED (saturating)
//   err_word_cnt  out  CW  bad words while LOCKED (saturating)
//   err_bit_cnt   out  CW  bad bits while LOCKED (saturating, macro only)
module prbs31_rx_checker
    import prbs31_pkg::*;
#(
    parameter int W         = 32,
    parameter int CW        = 32,
    parameter int LOCK_GOOD = 16,
    parameter int LOSE_BAD  = 4,
    parameter int LOSE_WIN  = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [W-1:0]  rx_data,
    input  logic          rx_vld,
    output logic          locked,
    output logic          lock_lost,
    output logic          err,
    output logic [1:0]    state,
    output logic [CW-1:0] word_cnt,
    output logic [CW-1:0] err_word_cnt
`ifdef PRBS31_CHK_BITERR_EN
    ,
    output logic [CW-1:0] err_bit_cnt
`endif
);

    localparam int GW = $clog2(LOCK_GOOD + 1);
    localparam int WW = $clog2(LOSE_WIN + 1);
    localparam int BW = $clog2(LOSE_BAD + 1);
    localparam int PW = $clog2(W + 1);
    localparam int SW = ((CW > PW) ? CW : PW) + 1;

    // The sum is kept wide enough that neither operand can wrap it, so any
    // carry above CW bits means the counter has hit its ceiling.
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] cnt,
                                              input logic [PW-1:0] inc);
        logic [SW-1:0] sum;
        sum = SW'(cnt) + SW'(inc);
        if (sum[SW-1:CW] != '0) begin
            return '1;
        end
        return sum[CW-1:0];
    endfunction

    logic [W-1:0]  d_q, d_d;
    logic          v_q, v_d;
    chk_state_e    state_q, state_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic [WW-1:0] win_cnt_q, win_cnt_d;
    logic [BW-1:0] bad_cnt_q, bad_cnt_d;
    logic          err_q, err_d;
    logic          lock_lost_q, lock_lost_d;
    logic [CW-1:0] word_cnt_q, word_cnt_d;
    logic [CW-1:0] err_word_cnt_q, err_word_cnt_d;

    logic          gen_load;
    logic          gen_adv;
    logic [W-1:0]  expected;
    logic          zero_word;
    logic          bad;
    logic          word_inc;
    logic          err_inc;

    // Outside LOCKED the generator is reloaded from every valid word, so its
    // output is always prbs31_next(previous valid word). Inside LOCKED it only
    // advances, except on the word that drops lock, which reseeds it so HUNT
    // sees the self-synchronising expectation again.
    prbs31_par_gen #(
        .W(W)
    ) u_gen (
        .clk  (clk),
        .rst  (rst),
        .load (gen_load),
        .adv  (gen_adv),
        .seed (d_q[W-1:W-PRBS31_LEN]),
        .word (expected)
    );

    // Comparator, lock FSM next state, window counters and word-level
    // statistics. Cycles without a valid registered word leave all of it alone.
    always_comb begin
        d_d            = rx_data;
        v_d            = rx_vld;
        state_d        = state_q;
        good_cnt_d     = good_cnt_q;
        win_cnt_d      = win_cnt_q;
        bad_cnt_d      = bad_cnt_q;
        err_d          = err_q;
        lock_lost_d    = 1'b0;
        gen_load       = 1'b0;
        gen_adv        = 1'b0;
        word_inc       = 1'b0;
        err_inc        = 1'b0;

        zero_word = prbs31_is_zero(PRBS31_MAX_W'(d_q));
        bad       = (d_q != expected) || ((state_q != LOCKED) && zero_word);

        if (v_q) begin
            err_d = bad;
            case (state_q)
                HUNT: begin
                    gen_load = 1'b1;
                    if (!zero_word) begin
                        state_d    = VERIFY;
                        good_cnt_d = '0;
                    end
                end
                VERIFY: begin
                    gen_load = 1'b1;
                    if (bad) begin
                        state_d = HUNT;
                    end else if (good_cnt_q == GW'(LOCK_GOOD - 1)) begin
                        state_d   = LOCKED;
                        win_cnt_d = '0;
                        bad_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + GW'(1);
                    end
                end
                LOCKED: begin
                    gen_adv  = 1'b1;
                    word_inc = 1'b1;
                    err_inc  = bad;
                    // The bad count is tested before the window wraps, so a
                    // bad word that closes a window still counts toward it.
                    if (bad && (bad_cnt_q == BW'(LOSE_BAD - 1))) begin
                        state_d     = HUNT;
                        lock_lost_d = 1'b1;
                        gen_load    = 1'b1;
                        win_cnt_d   = '0;
                        bad_cnt_d   = '0;
                    end else if (win_cnt_q == WW'(LOSE_WIN - 1)) begin
                        win_cnt_d = '0;
                        bad_cnt_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WW'(1);
                        bad_cnt_d = bad_cnt_q + BW'(bad);
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        if (clr) begin
            word_cnt_d     = '0;
            err_word_cnt_d = '0;
        end else begin
            word_cnt_d     = word_inc ? sat_add(word_cnt_q, PW'(1)) : word_cnt_q;
            err_word_cnt_d = err_inc ? sat_add(err_word_cnt_q, PW'(1)) : err_word_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q            <= '0;
            v_q            <= 1'b0;
            state_q        <= HUNT;
            good_cnt_q     <= '0;
            win_cnt_q      <= '0;
            bad_cnt_q      <= '0;
            err_q          <= 1'b0;
            lock_lost_q    <= 1'b0;
            word_cnt_q     <= '0;
            err_word_cnt_q <= '0;
        end else begin
            d_q            <= d_d;
            v_q            <= v_d;
            state_q        <= state_d;
            good_cnt_q     <= good_cnt_d;
            win_cnt_q      <= win_cnt_d;
            bad_cnt_q      <= bad_cnt_d;
            err_q          <= err_d;
            lock_lost_q    <= lock_lost_d;
            word_cnt_q     <= word_cnt_d;
            err_word_cnt_q <= err_word_cnt_d;
        end
    end

    assign locked       = (state_q == LOCKED);
    assign lock_lost    = lock_lost_q;
    assign err          = err_q;
    assign state        = state_q;
    assign word_cnt     = word_cnt_q;
    assign err_word_cnt = err_word_cnt_q;

`ifdef PRBS31_CHK_BITERR_EN
    localparam int NB = (W + 7) / 8;

    logic [NB*8-1:0] diff_pad;
    logic [3:0]      byte_cnt_d [NB];
    logic [3:0]      byte_cnt_q [NB];
    logic            byte_v_d, byte_v_q;
    logic [PW-1:0]   byte_sum;
    logic [CW-1:0]   err_bit_cnt_q, err_bit_cnt_d;

    // First stage registers per-byte popcounts of the mismatch vector; the
    // second stage sums the bytes straight into the counter. A clr drops any
    // popcount still in flight.
    always_comb begin
        diff_pad = (NB*8)'(d_q ^ expected);
        for (int b = 0; b < NB; b++) begin
            byte_cnt_d[b] = '0;
            for (int i = 0; i < 8; i++) begin
                byte_cnt_d[b] = byte_cnt_d[b] + 4'(diff_pad[b*8+i]);
            end
        end
        byte_v_d = v_q && (state_q == LOCKED) && !clr;

        byte_sum = '0;
        for (int b = 0; b < NB; b++) begin
            byte_sum = byte_sum + PW'(byte_cnt_q[b]);
        end

        if (clr) begin
            err_bit_cnt_d = '0;
        end else if (byte_v_q) begin
            err_bit_cnt_d = sat_add(err_bit_cnt_q, byte_sum);
        end else begin
            err_bit_cnt_d = err_bit_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                byte_cnt_q[b] <= '0;
            end
            byte_v_q      <= 1'b0;
            err_bit_cnt_q <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                byte_cnt_q[b] <= byte_cnt_d[b];
            end
            byte_v_q      <= byte_v_d;
            err_bit_cnt_q <= err_bit_cnt_d;
        end
    end

    assign err_bit_cnt = err_bit_cnt_q;
`endif

endmodule
